uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares one UART transmitter among NREQ byte producers (PicoBlaze output ports, debug sources). Each requester owns a one-byte holding slot. A round-robin arbiter picks among full slots, launches the chosen byte into the transmitter with a one-cycle `tx_start`, and waits for `tx_done_tick` before it launches the next byte. The block sits between the requesters and the transmitter's `tx_start`/`din`/`tx_done_tick` ports.

## Interface
- `NREQ`, 4: number of requesters, range 2..8
- `DBIT`, 8: byte width; must equal the transmitter's data width
- `GAP_CYCLES`, 0: idle clk cycles inserted after each `tx_done_tick`, range 0..255
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-low; low at a rising edge clears all state
- `wr` in NREQ: one-cycle write strobe per requester
- `wr_data` in NREQ*DBIT: requester i's byte is at bits [i*DBIT +: DBIT]
- `tx_done_tick` in 1: completion pulse from the transmitter
- `pend` out NREQ: slot i holds an unsent byte
- `overrun` out NREQ: one-cycle pulse; a write to full slot i was dropped
- `sent` out NREQ: one-cycle pulse; requester i's byte finished its stop bit
- `tx_start` out 1: one-cycle launch pulse to the transmitter
- `tx_din` out DBIT: byte for the transmitter; valid while `tx_start` is high
- `busy` out 1: high in every state except IDLE
- `cur_id` out clog2(NREQ): index of the requester being served

## Operation
- Reset values: `pend`, `overrun`, `sent`, `tx_start`, `busy`, `cur_id`, `tx_din` are all 0. The state is IDLE and the round-robin pointer is NREQ-1, so requester 0 wins first.
- Slot write:
  - If `wr[i]` is high and slot i is empty (or is being launched in the same cycle), the slot captures `wr_data` and sets `pend[i]`.
  - If `wr[i]` is high and slot i is full, the write is dropped and `overrun[i]` pulses in the next cycle. The slot contents are unchanged.
- State machine with states IDLE, LAUNCH, WAIT and GAP:
  - IDLE: if `pend` is nonzero, grant the first set bit searching upward from pointer+1 with wrap-around. Load `cur_id`, then go to LAUNCH.
  - LAUNCH: `tx_start`=1 and `tx_din`=slot[`cur_id`]. Clear `pend[cur_id]`, set pointer=`cur_id`, go to WAIT.
  - WAIT: on `tx_done_tick`, pulse `sent[cur_id]`. Go to GAP if `GAP_CYCLES`>0, otherwise go to IDLE.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- `tx_done_tick` outside WAIT is ignored.
- A write to slot i in the LAUNCH cycle for i is accepted. The launched byte is the old contents and `pend[i]` remains 1 (double buffering).
- A reset in any state aborts the operation. The in-flight byte is not reported as `sent`, and all slots are emptied.

## Timing
- Cycle n is the interval after rising edge n.
- Latency from `wr[i]` in cycle 0 with the block in IDLE:
  - `pend[i]`=1 in cycle 1
  - LAUNCH and `tx_start`=1 in cycle 2
  - `pend[i]`=0 in cycle 3, unless it was rewritten in cycle 2
- `tx_done_tick` in cycle k:
  - `sent` pulses in cycle k+1, with the state in IDLE or GAP
  - with `GAP_CYCLES`=0 and another slot pending, the next `tx_start` is in cycle k+2
  - with `GAP_CYCLES`=G, the next `tx_start` is in cycle k+G+2
- `tx_start` is exactly one cycle wide. `tx_din` is stable during it.
- `overrun` and `sent` are registered one-cycle pulses. Several bits may be set in the same cycle.
- Fairness: with all slots continuously refilled, the grant order is 0,1,…,NREQ-1,0,… with no requester skipped.

## Structure
- Shared package: the state encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, GAP=3) and an `ID_W = clog2(NREQ)` helper function.
- One sub-module, `rr_arbiter`:
  - inputs: request vector, pointer
  - outputs: grant index, any-grant flag
  - purely combinational, NREQ-generic
- Slot registers, the FSM and the gap counter live in `uart_tx_scheduler`.

## Test plan
- Single byte: hold `reset` low for 2 cycles. Pulse `wr[2]` with 0xA5 in cycle 0. Expect `tx_start` in cycle 2 with `tx_din`=0xA5 and `cur_id`=2. Drive `tx_done_tick` in cycle 20; expect `sent[2]` in cycle 21 and `busy`=0 in cycle 21.
- Round-robin: write all four slots (0x10, 0x11, 0x12, 0x13) in one cycle. Answer each launch with `tx_done_tick` 5 cycles later. Expect launch order 0,1,2,3 and `pend` clearing one bit at a time.
- Overrun: write 0x55 to slot 1 during WAIT on another requester, then write 0x66 to slot 1 one cycle later. Expect `overrun[1]` pulsed and 0x55 eventually launched.
- Same-cycle rewrite: write slot 0 during its own LAUNCH cycle. Expect the old byte launched, `pend[0]` still 1, and the new byte launched after the next done.
- Gap: with `GAP_CYCLES`=3 and two slots pending, drive `tx_done_tick` in cycle k. Expect the next `tx_start` in cycle k+5. A stray `tx_done_tick` during GAP has no effect.
- Reset mid-WAIT: drive `reset` low with 3 slots pending. Expect all outputs 0 next cycle, no `sent` pulse, and a later `tx_done_tick` ignored.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and width helpers.
package uart_tx_scheduler_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_LAUNCH_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC   = 2'd2;
    localparam logic [1:0] ST_GAP_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_LAUNCH = ST_LAUNCH_ENC,
        ST_WAIT   = ST_WAIT_ENC,
        ST_GAP    = ST_GAP_ENC
    } state_t;

    // Gap counter width; GAP_CYCLES never exceeds 255.
    localparam int GAP_W = 8;

    // Index width for a requester count, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant_id,
    output logic            any_grant
);

    // cand[k] is the requester k+1 positions after the pointer.
    logic [ID_W-1:0] cand [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = ID_W'((int'(ptr) + gi + 1) % NREQ);
    end

    // Scan from farthest to nearest so the nearest request wins.
    always_comb begin
        grant_id  = '0;
        any_grant = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant_id  = cand[k];
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ single-byte holding slots with round-robin
// arbitration, a one-cycle tx_start launch and an optional idle gap after each byte.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DBIT       = 8,
    parameter int GAP_CYCLES = 0,
    localparam int ID_W      = id_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ*DBIT-1:0] wr_data,
    input  logic                 tx_done_tick,
    output logic [NREQ-1:0]      pend,
    output logic [NREQ-1:0]      overrun,
    output logic [NREQ-1:0]      sent,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id
);

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   cur_id_reg, cur_id_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [NREQ-1:0]   pend_reg, pend_next;
    logic [NREQ-1:0]   overrun_reg, overrun_next;
    logic [NREQ-1:0]   sent_reg, sent_next;
    logic [DBIT-1:0]   slot_q [NREQ];
    logic [ID_W-1:0]   grant_id;
    logic              any_grant;
    logic              launch;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (pend_reg),
        .ptr       (ptr_reg),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    // A slot being launched this cycle may be refilled: its old byte goes out on
    // tx_din while the new byte is captured, so pend stays set.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        logic            launching;
        logic            accept;
        logic [DBIT-1:0] data_reg;

        assign launching = launch && (cur_id_reg == ID_W'(gi));
        assign accept    = wr[gi] && (!pend_reg[gi] || launching);

        assign pend_next[gi]    = accept || (pend_reg[gi] && !launching);
        assign overrun_next[gi] = wr[gi] && !accept;
        assign slot_q[gi]       = data_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                data_reg <= '0;
            end else if (accept) begin
                data_reg <= wr_data[gi*DBIT +: DBIT];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_id_next  = cur_id_reg;
        ptr_next     = ptr_reg;
        gap_cnt_next = gap_cnt_reg;
        sent_next    = '0;
        launch       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_grant) begin
                    cur_id_next = grant_id;
                    state_next  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                launch     = 1'b1;
                ptr_next   = cur_id_reg;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    sent_next[cur_id_reg] = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_next   = ST_GAP;
                        gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cur_id_reg  <= '0;
            ptr_reg     <= ID_W'(NREQ - 1);
            gap_cnt_reg <= '0;
            pend_reg    <= '0;
            overrun_reg <= '0;
            sent_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cur_id_reg  <= cur_id_next;
            ptr_reg     <= ptr_next;
            gap_cnt_reg <= gap_cnt_next;
            pend_reg    <= pend_next;
            overrun_reg <= overrun_next;
            sent_reg    <= sent_next;
        end
    end

    assign pend     = pend_reg;
    assign overrun  = overrun_reg;
    assign sent     = sent_reg;
    assign tx_start = (state_reg == ST_LAUNCH);
    assign tx_din   = tx_start ? slot_q[cur_id_reg] : '0;
    assign busy     = (state_reg != ST_IDLE);
    assign cur_id   = cur_id_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scenario bench for uart_tx_scheduler: expected launches are queued as stimulus is
// driven and compared by a monitor whenever tx_start fires.
module tb_uart_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int DBIT    = 8;
    localparam int MAX_CYC = 100;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with no gap
    logic              reset = 1'b0;
    logic [NREQ-1:0]   wr = '0;
    logic [NREQ*DBIT-1:0] wr_data = '0;
    logic              tx_done_tick = 1'b0;
    logic [NREQ-1:0]   pend, overrun, sent;
    logic              tx_start, busy;
    logic [DBIT-1:0]   tx_din;
    logic [1:0]        cur_id;

    // Instance with GAP_CYCLES = 3
    logic              g_reset = 1'b0;
    logic [NREQ-1:0]   g_wr = '0;
    logic [NREQ*DBIT-1:0] g_wr_data = '0;
    logic              g_tx_done_tick = 1'b0;
    logic [NREQ-1:0]   g_pend, g_overrun, g_sent;
    logic              g_tx_start, g_busy;
    logic [DBIT-1:0]   g_tx_din;
    logic [1:0]        g_cur_id;

    uart_tx_scheduler #(.NREQ(NREQ), .DBIT(DBIT), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data),
        .tx_done_tick(tx_done_tick), .pend(pend), .overrun(overrun), .sent(sent),
        .tx_start(tx_start), .tx_din(tx_din), .busy(busy), .cur_id(cur_id)
    );

    uart_tx_scheduler #(.NREQ(NREQ), .DBIT(DBIT), .GAP_CYCLES(3)) dut_g (
        .clk(clk), .reset(g_reset), .wr(g_wr), .wr_data(g_wr_data),
        .tx_done_tick(g_tx_done_tick), .pend(g_pend), .overrun(g_overrun), .sent(g_sent),
        .tx_start(g_tx_start), .tx_din(g_tx_din), .busy(g_busy), .cur_id(g_cur_id)
    );

    exp_t exp_q[$];
    exp_t gexp_q[$];
    exp_t m_e, g_e;
    int checks = 0;
    int errors = 0;
    int launches = 0;
    int g_launches = 0;

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            launches++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected got id=%0d din=%h exp none", cur_id, tx_din);
            end else begin
                m_e = exp_q.pop_front();
                if (cur_id !== m_e.id || tx_din !== m_e.data) begin
                    errors++;
                    $display("FAIL launch got id=%0d din=%h exp id=%0d din=%h",
                             cur_id, tx_din, m_e.id, m_e.data);
                end else begin
                    $display("launch id=%0d din=%h", cur_id, tx_din);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (g_tx_start === 1'b1) begin
            g_launches++;
            checks++;
            if (gexp_q.size() == 0) begin
                errors++;
                $display("FAIL g_launch_unexpected got id=%0d din=%h exp none", g_cur_id, g_tx_din);
            end else begin
                g_e = gexp_q.pop_front();
                if (g_cur_id !== g_e.id || g_tx_din !== g_e.data) begin
                    errors++;
                    $display("FAIL g_launch got id=%0d din=%h exp id=%0d din=%h",
                             g_cur_id, g_tx_din, g_e.id, g_e.data);
                end else begin
                    $display("g_launch id=%0d din=%h", g_cur_id, g_tx_din);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_launch(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic g_expect_launch(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        gexp_q.push_back(e);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < MAX_CYC) begin
            step();
            n++;
        end
        if (tx_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_start got timeout after %0d cycles exp tx_start", n);
        end
    endtask

    task automatic g_wait_start(output int n);
        n = 0;
        while (g_tx_start !== 1'b1 && n < MAX_CYC) begin
            step();
            n++;
        end
        if (g_tx_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL g_wait_start got timeout after %0d cycles exp tx_start", n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr = '0;
        tx_done_tick = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || gexp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got pending_launches=%0d/%0d exp 0/0", name, exp_q.size(), gexp_q.size());
        end else begin
            $display("%s drained", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({pend, overrun, sent, tx_start, busy, cur_id, tx_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pend=%b ovr=%b sent=%b start=%b busy=%b id=%0d din=%h exp all 0",
                     pend, overrun, sent, tx_start, busy, cur_id, tx_din);
        end else begin
            $display("reset outputs zero");
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        wr = 4'b0100;
        wr_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        expect_launch(2'd2, 8'hA5);
        step();                                   // cycle 1
        wr = '0;
        checks++;
        if (pend !== 4'b0100) begin
            errors++;
            $display("FAIL single_pend got %b exp 0100", pend);
        end
        step();                                   // cycle 2
        checks++;
        if (tx_start !== 1'b1 || cur_id !== 2'd2) begin
            errors++;
            $display("FAIL single_launch got start=%b id=%0d exp start=1 id=2", tx_start, cur_id);
        end
        step();                                   // cycle 3
        checks++;
        if (pend !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait got pend=%b start=%b busy=%b exp 0000 0 1", pend, tx_start, busy);
        end
        repeat (17) step();                       // cycle 20
        tx_done_tick = 1'b1;
        step();                                   // cycle 21
        tx_done_tick = 1'b0;
        checks++;
        if (sent !== 4'b0100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_sent got sent=%b busy=%b exp 0100 0", sent, busy);
        end else begin
            $display("single sent[2] ok");
        end
        step();
        checks++;
        if (sent !== 4'b0000) begin
            errors++;
            $display("FAIL single_sent_pulse got %b exp 0000", sent);
        end
        check_drained("single");
    endtask

    task automatic test_round_robin();
        int n;
        logic [3:0] m;
        do_reset();
        wr = 4'b1111;
        wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 4; k++) expect_launch(2'(k), 8'(8'h10 + k));
        step();
        wr = '0;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            m = 4'hF << k;
            checks++;
            if (pend !== m || (k > 0 && n != 1)) begin
                errors++;
                $display("FAIL rr_launch%0d got pend=%b steps=%0d exp pend=%b steps=1", k, pend, n, m);
            end
            repeat (5) step();
            tx_done_tick = 1'b1;
            step();
            tx_done_tick = 1'b0;
            m = 4'b0001 << k;
            checks++;
            if (sent !== m) begin
                errors++;
                $display("FAIL rr_sent%0d got %b exp %b", k, sent, m);
            end
        end
        check_drained("round_robin");
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        wr = 4'b1000;
        wr_data = {8'h77, 8'h00, 8'h00, 8'h00};
        expect_launch(2'd3, 8'h77);
        step();
        wr = '0;
        wait_start(n);
        step();                                   // WAIT on requester 3
        wr = 4'b0010;
        wr_data = {8'h00, 8'h00, 8'h55, 8'h00};
        expect_launch(2'd1, 8'h55);
        step();
        wr_data = {8'h00, 8'h00, 8'h66, 8'h00};
        step();
        wr = '0;
        checks++;
        if (overrun !== 4'b0010 || pend !== 4'b0010) begin
            errors++;
            $display("FAIL overrun_pulse got ovr=%b pend=%b exp 0010 0010", overrun, pend);
        end else begin
            $display("overrun[1] ok");
        end
        step();
        checks++;
        if (overrun !== 4'b0000) begin
            errors++;
            $display("FAIL overrun_width got %b exp 0000", overrun);
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        checks++;
        if (sent !== 4'b1000) begin
            errors++;
            $display("FAIL overrun_sent3 got %b exp 1000", sent);
        end
        wait_start(n);
        step();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        checks++;
        if (sent !== 4'b0010) begin
            errors++;
            $display("FAIL overrun_sent1 got %b exp 0010", sent);
        end
        repeat (5) step();
        check_drained("overrun");
    endtask

    task automatic test_rewrite();
        int n;
        do_reset();
        wr = 4'b0001;
        wr_data = {8'h00, 8'h00, 8'h00, 8'hA0};
        expect_launch(2'd0, 8'hA0);
        step();
        wr = '0;
        wait_start(n);                            // LAUNCH of slot 0
        wr = 4'b0001;
        wr_data = {8'h00, 8'h00, 8'h00, 8'hB0};
        expect_launch(2'd0, 8'hB0);
        step();
        wr = '0;
        checks++;
        if (pend !== 4'b0001 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL rewrite_pend got pend=%b ovr=%b exp 0001 0000", pend, overrun);
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        checks++;
        if (sent !== 4'b0001) begin
            errors++;
            $display("FAIL rewrite_sent got %b exp 0001", sent);
        end
        wait_start(n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL rewrite_relaunch got steps=%0d exp 1", n);
        end
        step();
        checks++;
        if (pend !== 4'b0000) begin
            errors++;
            $display("FAIL rewrite_pend_clear got %b exp 0000", pend);
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        check_drained("rewrite");
    endtask

    task automatic test_gap();
        int n;
        g_reset = 1'b0;
        step();
        step();
        g_reset = 1'b1;
        g_wr = 4'b0110;
        g_wr_data = {8'h00, 8'h22, 8'h21, 8'h00};
        g_expect_launch(2'd1, 8'h21);
        g_expect_launch(2'd2, 8'h22);
        step();
        g_wr = '0;
        g_wait_start(n);
        step();                                   // cycle k, WAIT
        g_tx_done_tick = 1'b1;
        step();                                   // k+1, GAP; stray done held
        checks++;
        if (g_sent !== 4'b0010 || g_busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_sent got sent=%b busy=%b exp 0010 1", g_sent, g_busy);
        end
        step();                                   // k+2
        g_tx_done_tick = 1'b0;
        checks++;
        if (g_sent !== 4'b0000 || g_busy !== 1'b1 || g_tx_start !== 1'b0) begin
            errors++;
            $display("FAIL gap_stray got sent=%b busy=%b start=%b exp 0000 1 0", g_sent, g_busy, g_tx_start);
        end
        g_wait_start(n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL gap_latency got start at k+%0d exp k+5", n + 2);
        end else begin
            $display("gap latency k+5 ok");
        end
        step();
        g_tx_done_tick = 1'b1;
        step();
        g_tx_done_tick = 1'b0;
        checks++;
        if (g_sent !== 4'b0100) begin
            errors++;
            $display("FAIL gap_sent2 got %b exp 0100", g_sent);
        end
        repeat (6) step();
        check_drained("gap");
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int l0;
        do_reset();
        wr = 4'b1111;
        wr_data = {8'h43, 8'h42, 8'h41, 8'h40};
        expect_launch(2'd0, 8'h40);
        step();
        wr = '0;
        wait_start(n);
        step();                                   // WAIT, three slots pending
        checks++;
        if (pend !== 4'b1110) begin
            errors++;
            $display("FAIL midreset_pend got %b exp 1110", pend);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if ({pend, overrun, sent, tx_start, busy, cur_id, tx_din} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got pend=%b ovr=%b sent=%b start=%b busy=%b id=%0d din=%h exp all 0",
                     pend, overrun, sent, tx_start, busy, cur_id, tx_din);
        end else begin
            $display("mid-wait reset outputs zero");
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        checks++;
        if (sent !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_done_ignored got sent=%b exp 0000", sent);
        end
        l0 = launches;
        repeat (10) step();
        checks++;
        if (launches != l0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got launches=%0d busy=%b exp %0d 0", launches, busy, l0);
        end
        check_drained("reset_mid_wait");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_rewrite();
        test_gap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
